mem_stage_ws: RTL and testbench

MEM_STAGE_WS -- requirements
Module: mem_stage_ws

---
 rtl/mem_stage_pkg.sv | 25 ++
 rtl/mem_lane_align.sv | 77 +++++++
 rtl/mem_stage_ws.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_stage_ws.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM pipeline stage: store/load size codes and the
// access-sequencer state type.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_SW = 2'b00,
        ST_SH = 2'b01,
        ST_SB = 2'b10
    } store_op_e;

    typedef enum logic [2:0] {
        LD_LW  = 3'b000,
        LD_LH  = 3'b001,
        LD_LHU = 3'b010,
        LD_LB  = 3'b011,
        LD_LBU = 3'b100
    } load_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: byte enables and replicated write data for
// stores, alignment check, and lane extraction with sign/zero extension.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [1:0]  flag_store_i,
    input  logic [2:0]  flag_load_i,
    input  logic [31:0] store_data_i,
    input  logic [1:0]  ext_addr_lo_i,
    input  logic [2:0]  ext_flag_load_i,
    input  logic [31:0] ext_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o,
    output logic [31:0] load_data_o
);

    logic [31:0] shifted;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Loads always fetch the full word; lane selection happens on the way back.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        be_o    = 4'b1111;
        wdata_o = store_data_i;
        if (mem_write_i) begin
            case (flag_store_i)
                ST_SH: begin
                    be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    wdata_o = {2{store_data_i[15:0]}};
                end
                ST_SB: begin
                    be_o    = 4'b0001 << addr_lo_i;
                    wdata_o = {4{store_data_i[7:0]}};
                end
                default: be_o = 4'b1111;
            endcase
        end
    end

    always_comb begin
        misaligned_o = 1'b0;
        if (mem_write_i) begin
            case (flag_store_i)
                ST_SH:   misaligned_o = addr_lo_i[0];
                ST_SB:   misaligned_o = 1'b0;
                default: misaligned_o = |addr_lo_i;
            endcase
        end else if (mem_read_i) begin
            case (flag_load_i)
                LD_LH, LD_LHU: misaligned_o = addr_lo_i[0];
                LD_LB, LD_LBU: misaligned_o = 1'b0;
                default:       misaligned_o = |addr_lo_i;
            endcase
        end
    end

    assign shifted   = ext_data_i >> {ext_addr_lo_i, 3'b000};
    assign lane_byte = shifted[7:0];
    assign lane_half = ext_addr_lo_i[1] ? ext_data_i[31:16] : ext_data_i[15:0];

    always_comb begin
        load_data_o = ext_data_i;
        case (ext_flag_load_i)
            LD_LH:   load_data_o = {{16{lane_half[15]}}, lane_half};
            LD_LHU:  load_data_o = {16'h0000, lane_half};
            LD_LB:   load_data_o = {{24{lane_byte[7]}}, lane_byte};
            LD_LBU:  load_data_o = {24'h000000, lane_byte};
            default: load_data_o = ext_data_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_ws.sv
// MEM pipeline stage with a wait-state memory port: one outstanding access,
// stall while waiting, timeout abort, MEM/WB latch and a store debug mirror.
module mem_stage_ws
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DBG_WORDS = 5,
    parameter int TIMEOUT   = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [31:0]             inMemAddress,
    input  logic [31:0]             inStoreData,
    input  logic                    MemWrite,
    input  logic                    MemRead,
    input  logic [1:0]              flagStore,
    input  logic [2:0]              flagLoad,
    input  logic [4:0]              inMuxRtRd,
    input  logic [4:0]              inRegRtMEM,
    input  logic [1:0]              inMemtoReg,
    input  logic                    inRegWrite,
    output logic                    memReq,
    output logic                    memWe,
    output logic [3:0]              memBe,
    output logic [ADDR_W-1:0]       memAddr,
    output logic [31:0]             memWdata,
    input  logic                    memAck,
    input  logic [31:0]             memRdata,
    output logic                    stallMEM,
    output logic                    misaligned,
    output logic                    busError,
    output logic [31:0]             outLoadData,
    output logic [31:0]             outAluLatch,
    output logic [1:0]              outMemtoReg,
    output logic                    outRegWrite,
    output logic [4:0]              outWriteReg,
    output logic [4:0]              outRegRtMEM,
    output logic [32*DBG_WORDS-1:0] debugWords
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam int                IDX_W    = ADDR_W - 2;
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_req_q;
    logic [ADDR_W-1:0]  req_addr_q;
    logic               req_we_q;
    logic [3:0]         req_be_q;
    logic [31:0]        req_wdata_q;
    logic               req_load_q;
    logic [2:0]         req_flag_q;
    logic [31:0]        hold_q;
    logic               timed_out_q;
    logic               mis_q, bus_err_q;

    logic [31:0]        ld_q, alu_q;
    logic [1:0]         m2r_q;
    logic               rw_q;
    logic [4:0]         wr_q, rt_q;
    logic [DBG_WORDS-1:0][31:0] dbg_q;

    logic        mem_op, is_load, mis_cond, access, stall;
    logic        ack_hit, tmo_hit, latch_en, dbg_we;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, load_ext, ld_d;
    logic        rw_d;
    logic [IDX_W-1:0] dbg_idx;

    mem_lane_align u_align (
        .addr_lo_i       (inMemAddress[1:0]),
        .mem_read_i      (MemRead),
        .mem_write_i     (MemWrite),
        .flag_store_i    (flagStore),
        .flag_load_i     (flagLoad),
        .store_data_i    (inStoreData),
        .ext_addr_lo_i   (req_addr_q[1:0]),
        .ext_flag_load_i (req_flag_q),
        .ext_data_i      (hold_q),
        .be_o            (be_c),
        .wdata_o         (wdata_c),
        .misaligned_o    (mis_cond),
        .load_data_o     (load_ext)
    );

    assign mem_op   = MemRead | MemWrite;
    assign is_load  = MemRead & ~MemWrite;
    assign access   = mem_op & enable & ~mis_cond;
    assign ack_hit  = (state_q == WAIT) & memAck;
    assign tmo_hit  = (state_q == WAIT) & ~memAck & (cnt_q == TMO_LAST);
    assign latch_en = enable & ~stall;
    assign dbg_we   = ack_hit & req_we_q;
    assign dbg_idx  = req_addr_q[ADDR_W-1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                    stall   = 1'b1;
                end
            end
            // enable is deliberately ignored here: a started access always completes or times out.
            WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (memAck || cnt_q == TMO_LAST) state_d = DONE;
            end
            DONE: begin
                if (enable) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            hold_q      <= '0;
            timed_out_q <= 1'b0;
            mis_q       <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_req_q <= (state_d == WAIT);
            mis_q     <= (state_q == IDLE) & mem_op & enable & mis_cond;
            bus_err_q <= tmo_hit;
            if (ack_hit) begin
                hold_q      <= memRdata;
                timed_out_q <= 1'b0;
            end else if (tmo_hit) begin
                hold_q      <= '0;
                timed_out_q <= 1'b1;
            end
        end
    end

    // Request fields are frozen on entry to WAIT so the bus stays stable while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_addr_q  <= '0;
            req_we_q    <= 1'b0;
            req_be_q    <= '0;
            req_wdata_q <= '0;
            req_load_q  <= 1'b0;
            req_flag_q  <= '0;
        end else if (state_q == IDLE && access) begin
            req_addr_q  <= inMemAddress[ADDR_W-1:0];
            req_we_q    <= MemWrite;
            req_be_q    <= be_c;
            req_wdata_q <= wdata_c;
            req_load_q  <= is_load;
            req_flag_q  <= flagLoad;
        end
    end

    always_comb begin
        ld_d = '0;
        rw_d = inRegWrite;
        if (state_q == DONE) begin
            if (req_load_q) ld_d = load_ext;
            if (req_load_q && timed_out_q) rw_d = 1'b0;
        end else if (is_load && mis_cond) begin
            rw_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_q  <= '0;
            alu_q <= '0;
            m2r_q <= '0;
            rw_q  <= 1'b0;
            wr_q  <= '0;
            rt_q  <= '0;
        end else if (latch_en) begin
            ld_q  <= ld_d;
            alu_q <= inMemAddress;
            m2r_q <= inMemtoReg;
            rw_q  <= rw_d;
            wr_q  <= inMuxRtRd;
            rt_q  <= inRegRtMEM;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the debug mirror is a small register file, so it is reset like any other state.
            dbg_q <= '0;
        end else if (dbg_we) begin
            for (int w = 0; w < DBG_WORDS; w++) begin
                if (dbg_idx == IDX_W'(w)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (req_be_q[b]) dbg_q[w][8*b +: 8] <= req_wdata_q[8*b +: 8];
                    end
                end
            end
        end
    end

    assign memReq      = mem_req_q;
    assign memWe       = req_we_q;
    assign memBe       = req_be_q;
    assign memAddr     = req_addr_q;
    assign memWdata    = req_wdata_q;
    assign stallMEM    = stall;
    assign misaligned  = mis_q;
    assign busError    = bus_err_q;
    assign outLoadData = ld_q;
    assign outAluLatch = alu_q;
    assign outMemtoReg = m2r_q;
    assign outRegWrite = rw_q;
    assign outWriteReg = wr_q;
    assign outRegRtMEM = rt_q;
    assign debugWords  = dbg_q;

endmodule

// File: tb/tb_mem_stage_ws.sv
// Scoreboard bench for mem_stage_ws: a word-array reference model predicts
// latch contents and bus requests; a memory responder and a latch monitor check them.
module tb_mem_stage_ws;

    localparam int ADDR_W = 10;
    localparam int DBG    = 5;
    localparam int TMO    = 15;

    typedef struct {
        logic        mw, mr;
        logic [1:0]  fs;
        logic [2:0]  fl;
        logic [31:0] addr, data;
        logic [4:0]  rd, rt;
        logic [1:0]  m2r;
        logic        rw;
    } op_t;

    typedef struct {
        logic [31:0] ld, alu;
        logic [1:0]  m2r;
        logic        rw;
        logic [4:0]  wr, rt;
        logic        mis;
    } exp_out_t;

    typedef struct {
        logic [9:0]  addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          delay;
    } req_t;

    logic clk = 1'b0;
    logic reset, enable, MemWrite, MemRead, inRegWrite, memAck;
    logic [31:0] inMemAddress, inStoreData, memRdata;
    logic [1:0]  flagStore, inMemtoReg;
    logic [2:0]  flagLoad;
    logic [4:0]  inMuxRtRd, inRegRtMEM;
    logic memReq, memWe, stallMEM, misaligned, busError, outRegWrite;
    logic [3:0]  memBe;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0] memWdata, outLoadData, outAluLatch;
    logic [1:0]  outMemtoReg;
    logic [4:0]  outWriteReg, outRegRtMEM;
    logic [32*DBG-1:0] debugWords;

    mem_stage_ws #(.ADDR_W(ADDR_W), .DBG_WORDS(DBG), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .inMemAddress(inMemAddress), .inStoreData(inStoreData),
        .MemWrite(MemWrite), .MemRead(MemRead),
        .flagStore(flagStore), .flagLoad(flagLoad),
        .inMuxRtRd(inMuxRtRd), .inRegRtMEM(inRegRtMEM),
        .inMemtoReg(inMemtoReg), .inRegWrite(inRegWrite),
        .memReq(memReq), .memWe(memWe), .memBe(memBe), .memAddr(memAddr),
        .memWdata(memWdata), .memAck(memAck), .memRdata(memRdata),
        .stallMEM(stallMEM), .misaligned(misaligned), .busError(busError),
        .outLoadData(outLoadData), .outAluLatch(outAluLatch),
        .outMemtoReg(outMemtoReg), .outRegWrite(outRegWrite),
        .outWriteReg(outWriteReg), .outRegRtMEM(outRegRtMEM),
        .debugWords(debugWords)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    exp_out_t exp_q[$];
    req_t     req_q[$];
    req_t     cur_req;
    logic [31:0] ram[256];
    logic [31:0] ref_mem[256];
    logic [31:0] dbg_exp[DBG];
    int  bus_exp = 0, bus_seen = 0, last_stall = 0;
    bit  resp_en = 0, mon_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic op_t mk_op(input logic mw, input logic mr, input logic [1:0] fs,
                                  input logic [2:0] fl, input logic [31:0] addr,
                                  input logic [31:0] data);
        op_t o;
        logic [31:0] r;
        r = $urandom;
        o.mw = mw; o.mr = mr; o.fs = fs; o.fl = fl; o.addr = addr; o.data = data;
        o.rd = r[4:0]; o.rt = r[9:5]; o.m2r = r[11:10];
        o.rw = mr ? 1'b1 : r[12];
        return o;
    endfunction

    function automatic int op_size(input op_t o);
        if (o.mw) return (o.fs == 2'd1) ? 2 : (o.fs == 2'd2) ? 1 : 4;
        if (o.fl == 3'd1 || o.fl == 3'd2) return 2;
        if (o.fl == 3'd3 || o.fl == 3'd4) return 1;
        return 4;
    endfunction

    // Reference model: predicts bus request and latch contents from the size/offset rules.
    task automatic predict(input op_t op, input int delay);
        exp_out_t e;
        req_t     q;
        int size, off, idx;
        logic [31:0] w, b, h;
        bit is_load, mem, misal;
        is_load = op.mr && !op.mw;
        mem     = op.mr || op.mw;
        size    = op_size(op);
        off     = int'(op.addr % 4);
        idx     = int'((op.addr >> 2) % 256);
        misal   = mem && (op.addr % size != 0);
        e.ld = 0; e.alu = op.addr; e.m2r = op.m2r; e.rw = op.rw;
        e.wr = op.rd; e.rt = op.rt; e.mis = misal;
        if (misal) begin
            if (is_load) e.rw = 1'b0;
        end else if (mem) begin
            q.addr = op.addr[9:0]; q.we = op.mw; q.delay = delay;
            q.wdata = (size == 4) ? op.data : (size == 2) ? {2{op.data[15:0]}} : {4{op.data[7:0]}};
            q.be = !op.mw ? 4'hF : (size == 4) ? 4'hF : (size == 2) ? 4'(3 << off) : 4'(1 << off);
            req_q.push_back(q);
            if (delay == 0) begin
                bus_exp++;
                if (is_load) e.rw = 1'b0;
            end else if (op.mw) begin
                for (int k = 0; k < 4; k++) begin
                    if (q.be[k]) begin
                        ref_mem[idx][8*k +: 8] = q.wdata[8*k +: 8];
                        if (idx < DBG) dbg_exp[idx][8*k +: 8] = q.wdata[8*k +: 8];
                    end
                end
            end else begin
                w = ref_mem[idx];
                b = (w >> (8 * off)) % 256;
                h = (w >> (8 * off)) % 65536;
                case (op.fl)
                    3'd1:    e.ld = h - ((h & 32768) << 1);
                    3'd2:    e.ld = h;
                    3'd3:    e.ld = b - ((b & 128) << 1);
                    3'd4:    e.ld = b;
                    default: e.ld = w;
                endcase
            end
        end
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the instruction was latched.
    task automatic issue(input op_t op, input int delay, input bit rand_en);
        bit done;
        predict(op, delay);
        MemWrite = op.mw; MemRead = op.mr; flagStore = op.fs; flagLoad = op.fl;
        inMemAddress = op.addr; inStoreData = op.data; inMuxRtRd = op.rd;
        inRegRtMEM = op.rt; inMemtoReg = op.m2r; inRegWrite = op.rw;
        last_stall = 0;
        done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            enable = (rand_en && $urandom_range(0, 4) == 0) ? 1'b0 : 1'b1;
            #1;
            if (stallMEM) last_stall++;
            if (enable && !stallMEM) done = 1;
        end
        check("issue_captured", 32'(done), 1);
        @(posedge clk);
        #1;
        MemWrite = 1'b0; MemRead = 1'b0; enable = 1'b0;
    endtask

    // Latch monitor: after every capture edge, compare latch outputs with the scoreboard.
    bit pend = 0;
    initial begin
        exp_out_t e;
        forever begin
            @(negedge clk);
            if (mon_en && pend) begin
                check("sb_has_entry", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("outLoadData", outLoadData, e.ld);
                    check("outAluLatch", outAluLatch, e.alu);
                    check("outMemtoReg", 32'(outMemtoReg), 32'(e.m2r));
                    check("outRegWrite", 32'(outRegWrite), 32'(e.rw));
                    check("outWriteReg", 32'(outWriteReg), 32'(e.wr));
                    check("outRegRtMEM", 32'(outRegRtMEM), 32'(e.rt));
                    check("misaligned", 32'(misaligned), 32'(e.mis));
                end
            end
            #2;
            pend = mon_en && reset && enable && !stallMEM;
        end
    end

    always @(negedge clk) if (busError) bus_seen++;

    // Memory responder: checks each request, acks after its delay, injects stray acks when idle.
    initial begin
        bit in_txn;
        int wcnt;
        in_txn = 0; wcnt = 0;
        memAck = 1'b0; memRdata = '0;
        forever begin
            @(negedge clk);
            if (!resp_en) begin
                in_txn = 0;
                continue;
            end
            memAck = 1'b0;
            memRdata = $urandom;
            if (memReq) begin
                if (!in_txn) begin
                    in_txn = 1; wcnt = 0;
                    check("req_expected", 32'(req_q.size() != 0), 1);
                    if (req_q.size() != 0) cur_req = req_q.pop_front();
                    check("memAddr", 32'(memAddr), 32'(cur_req.addr));
                    check("memWe", 32'(memWe), 32'(cur_req.we));
                    check("memBe", 32'(memBe), 32'(cur_req.be));
                    if (cur_req.we) check("memWdata", memWdata, cur_req.wdata);
                end
                wcnt++;
                if (wcnt == cur_req.delay) begin
                    memAck = 1'b1;
                    memRdata = ram[memAddr[9:2]];
                    if (memWe)
                        for (int k = 0; k < 4; k++)
                            if (memBe[k]) ram[memAddr[9:2]][8*k +: 8] = memWdata[8*k +: 8];
                end
            end else begin
                if (in_txn) begin
                    in_txn = 0;
                    check("wait_cycles", 32'(wcnt), 32'((cur_req.delay == 0) ? TMO : cur_req.delay));
                end
                if ($urandom_range(0, 3) == 0) memAck = 1'b1;
            end
        end
    end

    task automatic check_dbg(input string tag);
        for (int i = 0; i < DBG; i++) check({tag, "_dbg"}, debugWords[32*i +: 32], dbg_exp[i]);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_memReq"}, 32'(memReq), 0);
        check({tag, "_stallMEM"}, 32'(stallMEM), 0);
        check({tag, "_misaligned"}, 32'(misaligned), 0);
        check({tag, "_busError"}, 32'(busError), 0);
        check({tag, "_outLoadData"}, outLoadData, 0);
        check({tag, "_outAluLatch"}, outAluLatch, 0);
        check({tag, "_outRegWrite"}, 32'(outRegWrite), 0);
        check({tag, "_outWriteReg"}, 32'(outWriteReg), 0);
        check({tag, "_debugWords"}, 32'(debugWords != '0), 0);
    endtask

    task automatic random_ops(input int n);
        op_t o;
        logic [31:0] r;
        logic [9:0] lo;
        int kind, dly;
        for (int i = 0; i < n; i++) begin
            r = $urandom;
            lo = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 31));
            kind = $urandom_range(0, 9);
            if (kind < 3)      o = mk_op(1'b0, 1'b0, 2'($urandom_range(0, 2)), 3'($urandom_range(0, 4)), {r[31:10], lo}, $urandom);
            else if (kind < 6) o = mk_op(1'b1, 1'b0, 2'($urandom_range(0, 2)), 3'd0, {r[31:10], lo}, $urandom);
            else               o = mk_op(1'b0, 1'b1, 2'd0, 3'($urandom_range(0, 4)), {r[31:10], lo}, $urandom);
            if ($urandom_range(0, 1) == 0) o.addr = o.addr & ~32'(op_size(o) - 1);
            dly = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
            issue(o, dly, 1'b1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; enable = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
        flagStore = '0; flagLoad = '0; inMemAddress = '0; inStoreData = '0;
        inMuxRtRd = '0; inRegRtMEM = '0; inMemtoReg = '0; inRegWrite = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ram[i] = $urandom;
            ref_mem[i] = ram[i];
        end
        for (int i = 0; i < DBG; i++) dbg_exp[i] = '0;
        resp_en = 1;
        repeat (2) @(negedge clk);
        #1;
        check_zero_outputs("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1;

        // SW 0xDEADBEEF to 0x8 with ack in the second WAIT cycle
        issue(mk_op(1'b1, 1'b0, 2'd0, 3'd0, 32'h8, 32'hDEADBEEF), 2, 1'b0);
        check("sw_stall_cycles", 32'(last_stall), 3);
        check("sw_dbg2", debugWords[64 +: 32], 32'hDEADBEEF);
        // sub-word loads from that word
        issue(mk_op(1'b0, 1'b1, 2'd0, 3'd3, 32'h9, 32'h0), 1, 1'b0);
        issue(mk_op(1'b0, 1'b1, 2'd0, 3'd4, 32'h9, 32'h0), 1, 1'b0);
        issue(mk_op(1'b0, 1'b1, 2'd0, 3'd1, 32'hA, 32'h0), 1, 1'b0);
        issue(mk_op(1'b0, 1'b1, 2'd0, 3'd2, 32'hA, 32'h0), 2, 1'b0);
        // byte store into the top lane of word 0
        issue(mk_op(1'b1, 1'b0, 2'd0, 3'd0, 32'h0, 32'h11223344), 1, 1'b0);
        issue(mk_op(1'b1, 1'b0, 2'd2, 3'd0, 32'h3, 32'h00000055), 3, 1'b0);
        check("sb_dbg0", debugWords[0 +: 32], 32'h55223344);
        // misaligned halfword load
        issue(mk_op(1'b0, 1'b1, 2'd0, 3'd1, 32'h5, 32'h0), 1, 1'b0);
        check("mis_stall_cycles", 32'(last_stall), 0);
        // load that is never acknowledged
        issue(mk_op(1'b0, 1'b1, 2'd0, 3'd0, 32'h14, 32'h0), 0, 1'b0);
        check("tmo_stall_cycles", 32'(last_stall), 32'(TMO + 1));
        issue(mk_op(1'b0, 1'b0, 2'd0, 3'd0, 32'h1234, 32'h0), 1, 1'b0);
        check("after_tmo_passthru_stall", 32'(last_stall), 0);
        check_dbg("directed");

        random_ops(150);
        check_dbg("random");

        // reset in the middle of WAIT, then a stray ack
        repeat (2) @(negedge clk);
        check("sb_drained_pre_reset", 32'(exp_q.size()), 0);
        mon_en = 0;
        resp_en = 0;
        memAck = 1'b0;
        MemRead = 1'b1; MemWrite = 1'b0; flagLoad = 3'd0; inMemAddress = 32'h10;
        inRegWrite = 1'b1; enable = 1'b1;
        for (int c = 0; c < 20 && !memReq; c++) @(negedge clk);
        check("reset_test_req_seen", 32'(memReq), 1);
        repeat (2) @(negedge clk);
        reset = 1'b0; enable = 1'b0; MemRead = 1'b0;
        #1;
        check_zero_outputs("midwait_reset");
        @(negedge clk);
        reset = 1'b1;
        memAck = 1'b1; memRdata = 32'hCAFEF00D;
        repeat (2) @(negedge clk);
        memAck = 1'b0;
        #1;
        check("late_ack_memReq", 32'(memReq), 0);
        check("late_ack_stall", 32'(stallMEM), 0);
        check("late_ack_ld", outLoadData, 0);
        for (int i = 0; i < DBG; i++) dbg_exp[i] = '0;
        check_dbg("post_reset");
        req_q.delete();
        @(posedge clk);
        #1;
        mon_en = 1;
        resp_en = 1;
        random_ops(40);
        check_dbg("final");

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 0);
        check("req_drained", 32'(req_q.size()), 0);
        check("busError_pulses", 32'(bus_seen), 32'(bus_exp));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
